id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  core clock, all state on rising edge; rst_i  in  1  reset, asynchronous, active-high.
REQ-002 SHALL have decode inputs: id_valid_i in 1; id_pc_i in 32; id_rs1_data_i, id_rs2_data_i in 32 (register-file read data); id_imm_i in 32 (extended immediate); id_rs1_i, id_rs2_i, id_rd_i in 5; id_uses_rs1_i, id_uses_rs2_i in 1; id_ctrl_i in 16 (bit0 reg_write, bit1 mem_read, bit2 mem_write, bits15:3 opaque).
REQ-003 SHALL have control inputs: flush_i in 1 (taken branch/jump); ex_stall_i in 1 (downstream hold).
REQ-004 SHALL have bypass inputs: mem_rd_i in 5, mem_reg_write_i in 1, mem_result_i in 32; wb_rd_i in 5, wb_reg_write_i in 1, wb_result_i in 32.
REQ-005 SHALL have outputs: id_ready_o out 1; ex_valid_o out 1; ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o out 32; ex_rd_o out 5; ex_ctrl_o out 16; hazard_stall_o out 1; bubble_cnt_o out 16.

Function
REQ-006 SHALL capture all id_* fields into ex_* registers on a rising edge when id_valid_i=1, id_ready_o=1, ex_stall_i=0, flush_i=0; ex_valid_o<=1.
REQ-007 SHALL, when id_valid_i=0 and not stalled, load ex_valid_o<=0 and ex_ctrl_o<=0 (bubble); data fields don't-care.
REQ-008 SHALL, on ex_stall_i=1 and flush_i=0, hold every ex_* register; id_ready_o=0.
REQ-009 SHALL, on flush_i=1, load ex_valid_o<=0, ex_ctrl_o<=0 next edge regardless of ex_stall_i or hazards; id_ready_o=0 that cycle.
REQ-010 SHALL detect load-use hazard combinationally: ex_valid_o=1, ex_ctrl_o[1]=1, ex_rd_o!=0, and (id_uses_rs1_i & id_rs1_i==ex_rd_o or id_uses_rs2_i & id_rs2_i==ex_rd_o), id_valid_i=1.
REQ-011 SHALL on hazard drive hazard_stall_o=1, id_ready_o=0, insert one bubble (ex_valid_o<=0, ex_ctrl_o<=0); decode inputs re-presented next cycle.
REQ-012 SHALL apply priority: rst_i > flush_i > ex_stall_i > hazard > capture.
REQ-013 SHALL drive id_ready_o = !(flush_i | ex_stall_i | hazard_stall_o).
REQ-014 SHALL never treat x0 as a dependency: rd/rs==0 never stalls or forwards.
REQ-015 SHALL increment bubble_cnt_o by 1 on each edge where a hazard bubble is inserted, saturating at 16'hFFFF; flush and ex_stall do not count.
REQ-016 SHALL rely on register-file write-on-falling-edge: WB writes are visible in id_rs*_data_i same cycle; no WB-stage stall needed.

Reset
REQ-017 SHALL on rst_i=1 asynchronously clear ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_rd_o, ex_ctrl_o, bubble_cnt_o to 0.
REQ-018 SHALL drive id_ready_o=0, hazard_stall_o=0 while rst_i=1; first capture on first rising edge after deassertion.
REQ-019 SHALL abandon any in-flight instruction on reset mid-stall; no state survives.

Configuration
REQ-020 SHALL support macro ID_EX_FORWARDING_EN.
REQ-021 SHALL, with ID_EX_FORWARDING_EN defined, substitute captured rs1/rs2 data: mem_result_i if mem_reg_write_i & mem_rd_i==rs & rs!=0, else wb_result_i if wb_reg_write_i & wb_rd_i==rs & rs!=0, else id_rs*_data_i; MEM priority over WB.
REQ-022 SHALL, without ID_EX_FORWARDING_EN, capture id_rs*_data_i unchanged and extend hazard (REQ-010) to any RAW: valid EX instruction with ex_ctrl_o[0]=1, or mem_reg_write_i=1, with matching nonzero rd; stall repeats each cycle until cleared; each stalled cycle counts in bubble_cnt_o.

Verification
REQ-023 SHALL cover: reset mid-operation, rst_i=1 async between edges -> all ex_* and bubble_cnt_o read 0 immediately.
REQ-024 SHALL cover: lw x5 in EX, then add x6,x5,x7 valid -> hazard_stall_o=1 one cycle, one bubble, add captured next cycle, bubble_cnt_o=1.
REQ-025 SHALL cover: ex_stall_i=1 for 3 cycles with valid EX instruction pc=0x100 -> ex_pc_o holds 0x100, id_ready_o=0 throughout.
REQ-026 SHALL cover: flush_i=1 and ex_stall_i=1 same cycle -> ex_valid_o=0 next edge.
REQ-027 SHALL cover (FORWARDING_EN): mem_rd_i=3 result 0xAAAA, wb_rd_i=3 result 0xBBBB, rs1=3 -> ex_rs1_data_o=0xAAAA; rs1=0 with mem_rd_i=0 -> RF value unchanged.
REQ-028 SHALL cover: 65 540 forced load-use bubbles -> bubble_cnt_o saturates at 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
`timescale 1ns/1ps
// ID/EX pipeline register with load-use / RAW hazard detection and a saturating bubble counter.
// Optional MEM/WB operand forwarding is enabled by defining ID_EX_FORWARDING_EN.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_i,

    input  logic        id_valid_i,
    input  logic [31:0] id_pc_i,
    input  logic [31:0] id_rs1_data_i,
    input  logic [31:0] id_rs2_data_i,
    input  logic [31:0] id_imm_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic [4:0]  id_rd_i,
    input  logic        id_uses_rs1_i,
    input  logic        id_uses_rs2_i,
    input  logic [15:0] id_ctrl_i,

    input  logic        flush_i,
    input  logic        ex_stall_i,

    input  logic [4:0]  mem_rd_i,
    input  logic        mem_reg_write_i,
    input  logic [31:0] mem_result_i,
    input  logic [4:0]  wb_rd_i,
    input  logic        wb_reg_write_i,
    input  logic [31:0] wb_result_i,

    output logic        id_ready_o,
    output logic        ex_valid_o,
    output logic [31:0] ex_pc_o,
    output logic [31:0] ex_rs1_data_o,
    output logic [31:0] ex_rs2_data_o,
    output logic [31:0] ex_imm_o,
    output logic [4:0]  ex_rd_o,
    output logic [15:0] ex_ctrl_o,
    output logic        hazard_stall_o,
    output logic [15:0] bubble_cnt_o
);

    logic        r_ex_valid;
    logic [31:0] r_ex_pc;
    logic [31:0] r_ex_rs1_data;
    logic [31:0] r_ex_rs2_data;
    logic [31:0] r_ex_imm;
    logic [4:0]  r_ex_rd;
    logic [15:0] r_ex_ctrl;
    logic [15:0] r_bubble_cnt;

    logic        w_dep_ex;
    logic        w_load_use;
    logic        w_hazard;
    logic        w_advance;
    logic        w_capture;
    logic        w_hz_bubble;
    logic [31:0] w_rs1_data;
    logic [31:0] w_rs2_data;

    // x0 is never a dependency: a zero rd can never match.
    function automatic logic src_dep(input logic uses, input logic [4:0] rs, input logic [4:0] rd);
        return uses && (rd != 5'd0) && (rs == rd);
    endfunction

    assign w_dep_ex   = src_dep(id_uses_rs1_i, id_rs1_i, r_ex_rd)
                      | src_dep(id_uses_rs2_i, id_rs2_i, r_ex_rd);
    assign w_load_use = id_valid_i & r_ex_valid & r_ex_ctrl[1] & w_dep_ex;

`ifdef ID_EX_FORWARDING_EN
    function automatic logic [31:0] fwd(
        input logic [4:0]  rs,
        input logic [31:0] rf_data,
        input logic        mem_we,
        input logic [4:0]  mem_rd,
        input logic [31:0] mem_res,
        input logic        wb_we,
        input logic [4:0]  wb_rd,
        input logic [31:0] wb_res
    );
        logic [31:0] v;
        v = rf_data;
        if (rs != 5'd0 && mem_we && mem_rd == rs)
            v = mem_res;
        else if (rs != 5'd0 && wb_we && wb_rd == rs)
            v = wb_res;
        return v;
    endfunction

    assign w_hazard   = w_load_use;
    assign w_rs1_data = fwd(id_rs1_i, id_rs1_data_i, mem_reg_write_i, mem_rd_i, mem_result_i,
                            wb_reg_write_i, wb_rd_i, wb_result_i);
    assign w_rs2_data = fwd(id_rs2_i, id_rs2_data_i, mem_reg_write_i, mem_rd_i, mem_result_i,
                            wb_reg_write_i, wb_rd_i, wb_result_i);
`else
    logic w_raw_ex;
    logic w_raw_mem;
    logic w_unused_bypass;

    // Without bypassing, any in-flight producer in EX or MEM must drain first.
    assign w_raw_ex   = id_valid_i & r_ex_valid & r_ex_ctrl[0] & w_dep_ex;
    assign w_raw_mem  = id_valid_i & mem_reg_write_i
                      & (src_dep(id_uses_rs1_i, id_rs1_i, mem_rd_i)
                       | src_dep(id_uses_rs2_i, id_rs2_i, mem_rd_i));
    assign w_hazard   = w_load_use | w_raw_ex | w_raw_mem;
    assign w_rs1_data = id_rs1_data_i;
    assign w_rs2_data = id_rs2_data_i;
    assign w_unused_bypass = ^{mem_result_i, wb_rd_i, wb_reg_write_i, wb_result_i};
`endif

    assign w_advance   = ~flush_i & ~ex_stall_i;
    assign w_hz_bubble = w_advance & w_hazard;
    assign w_capture   = w_advance & ~w_hazard & id_valid_i;

    assign hazard_stall_o = w_hazard & ~rst_i;
    assign id_ready_o     = ~(rst_i | flush_i | ex_stall_i | w_hazard);

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_ex_valid    <= 1'b0;
            r_ex_pc       <= '0;
            r_ex_rs1_data <= '0;
            r_ex_rs2_data <= '0;
            r_ex_imm      <= '0;
            r_ex_rd       <= '0;
            r_ex_ctrl     <= '0;
        end else if (flush_i) begin
            r_ex_valid <= 1'b0;
            r_ex_ctrl  <= '0;
        end else if (!ex_stall_i) begin
            if (w_capture) begin
                r_ex_valid    <= 1'b1;
                r_ex_pc       <= id_pc_i;
                r_ex_rs1_data <= w_rs1_data;
                r_ex_rs2_data <= w_rs2_data;
                r_ex_imm      <= id_imm_i;
                r_ex_rd       <= id_rd_i;
                r_ex_ctrl     <= id_ctrl_i;
            end else begin
                r_ex_valid <= 1'b0;
                r_ex_ctrl  <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i)
            r_bubble_cnt <= '0;
        else if (w_hz_bubble && r_bubble_cnt != '1)
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end

    assign ex_valid_o    = r_ex_valid;
    assign ex_pc_o       = r_ex_pc;
    assign ex_rs1_data_o = r_ex_rs1_data;
    assign ex_rs2_data_o = r_ex_rs2_data;
    assign ex_imm_o      = r_ex_imm;
    assign ex_rd_o       = r_ex_rd;
    assign ex_ctrl_o     = r_ex_ctrl;
    assign bubble_cnt_o  = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
`timescale 1ns/1ps
// Scoreboard bench for id_ex_stage: stimulus queues expected EX state, a monitor checks it after each edge.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        id_valid_i;
    logic [31:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
    logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
    logic        id_uses_rs1_i, id_uses_rs2_i;
    logic [15:0] id_ctrl_i;
    logic        flush_i, ex_stall_i;
    logic [4:0]  mem_rd_i, wb_rd_i;
    logic        mem_reg_write_i, wb_reg_write_i;
    logic [31:0] mem_result_i, wb_result_i;
    logic        id_ready_o, ex_valid_o, hazard_stall_o;
    logic [31:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
    logic [4:0]  ex_rd_o;
    logic [15:0] ex_ctrl_o, bubble_cnt_o;

    id_ex_stage dut (
        .clk(clk), .rst_i(rst_i),
        .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
        .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
        .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i), .id_ctrl_i(id_ctrl_i),
        .flush_i(flush_i), .ex_stall_i(ex_stall_i),
        .mem_rd_i(mem_rd_i), .mem_reg_write_i(mem_reg_write_i), .mem_result_i(mem_result_i),
        .wb_rd_i(wb_rd_i), .wb_reg_write_i(wb_reg_write_i), .wb_result_i(wb_result_i),
        .id_ready_o(id_ready_o), .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o),
        .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o), .ex_imm_o(ex_imm_o),
        .ex_rd_o(ex_rd_o), .ex_ctrl_o(ex_ctrl_o), .hazard_stall_o(hazard_stall_o),
        .bubble_cnt_o(bubble_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rd;
        logic [15:0] ctrl, cnt;
        bit          dat;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [15:0] c;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t cap(input logic [31:0] pc, d1, d2, imm, input logic [4:0] rd,
                                 input logic [15:0] ctrl, cnt);
        exp_t e;
        e.v = 1'b1; e.pc = pc; e.d1 = d1; e.d2 = d2; e.imm = imm;
        e.rd = rd; e.ctrl = ctrl; e.cnt = cnt; e.dat = 1'b1;
        return e;
    endfunction

    function automatic exp_t bub(input logic [15:0] cnt);
        exp_t e;
        e.v = 1'b0; e.pc = '0; e.d1 = '0; e.d2 = '0; e.imm = '0;
        e.rd = '0; e.ctrl = '0; e.cnt = cnt; e.dat = 1'b0;
        return e;
    endfunction

    task automatic drv(input logic v, input logic [31:0] pc, d1, d2, imm,
                       input logic [4:0] s1, s2, rd, input logic u1, u2, input logic [15:0] ctl);
        id_valid_i = v; id_pc_i = pc; id_rs1_data_i = d1; id_rs2_data_i = d2; id_imm_i = imm;
        id_rs1_i = s1; id_rs2_i = s2; id_rd_i = rd;
        id_uses_rs1_i = u1; id_uses_rs2_i = u2; id_ctrl_i = ctl;
    endtask

    // Called at a falling edge with inputs already driven; -1 skips a combinational check.
    task automatic go(input int er, input int eh, input exp_t e);
        #1;
        if (er >= 0) chk("id_ready", {31'd0, id_ready_o}, er);
        if (eh >= 0) chk("hazard_stall", {31'd0, hazard_stall_o}, eh);
        q.push_back(e);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            me = q.pop_front();
            chk("ex_valid", {31'd0, ex_valid_o}, {31'd0, me.v});
            chk("ex_ctrl", {16'd0, ex_ctrl_o}, {16'd0, me.ctrl});
            chk("bubble_cnt", {16'd0, bubble_cnt_o}, {16'd0, me.cnt});
            if (me.dat) begin
                chk("ex_pc", ex_pc_o, me.pc);
                chk("ex_rs1_data", ex_rs1_data_o, me.d1);
                chk("ex_rs2_data", ex_rs2_data_o, me.d2);
                chk("ex_imm", ex_imm_o, me.imm);
                chk("ex_rd", {27'd0, ex_rd_o}, {27'd0, me.rd});
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish (queue %0d)", q.size());
        $fatal(1, "watchdog");
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, ex_valid_o}, 0);
        chk({tag, "_pc"}, ex_pc_o, 0);
        chk({tag, "_rs1"}, ex_rs1_data_o, 0);
        chk({tag, "_rs2"}, ex_rs2_data_o, 0);
        chk({tag, "_imm"}, ex_imm_o, 0);
        chk({tag, "_rd"}, {27'd0, ex_rd_o}, 0);
        chk({tag, "_ctrl"}, {16'd0, ex_ctrl_o}, 0);
        chk({tag, "_cnt"}, {16'd0, bubble_cnt_o}, 0);
        chk({tag, "_ready"}, {31'd0, id_ready_o}, 0);
        chk({tag, "_hazard"}, {31'd0, hazard_stall_o}, 0);
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; ex_stall_i = 1'b0;
        mem_rd_i = '0; mem_reg_write_i = 1'b0; mem_result_i = '0;
        wb_rd_i = '0; wb_reg_write_i = 1'b0; wb_result_i = '0;
        drv(1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        c = 16'd0;
        @(negedge clk); #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_i = 1'b0;

        // plain capture, then an id_valid=0 bubble
        drv(1, 32'h10, 32'h11, 32'h22, 32'h33, 2, 3, 1, 1, 1, 16'h0001);
        go(1, 0, cap(32'h10, 32'h11, 32'h22, 32'h33, 1, 16'h0001, c));
        id_valid_i = 1'b0;
        go(1, 0, bub(c));

        // lw x5 then add x6,x5,x7: one bubble, then the add goes through
        drv(1, 32'h20, 32'hA, 32'hB, 32'h4, 1, 0, 5, 1, 0, 16'h0003);
        go(1, 0, cap(32'h20, 32'hA, 32'hB, 32'h4, 5, 16'h0003, c));
        drv(1, 32'h24, 32'h50, 32'h70, 32'h0, 5, 7, 6, 1, 1, 16'h0001);
        c = 16'd1;
        go(0, 1, bub(c));
        go(1, 0, cap(32'h24, 32'h50, 32'h70, 32'h0, 6, 16'h0001, c));

        // ALU result of x6 consumed immediately
        drv(1, 32'h28, 32'h1, 32'h2, 32'h3, 6, 0, 8, 1, 0, 16'h0001);
`ifdef ID_EX_FORWARDING_EN
        go(1, 0, cap(32'h28, 32'h1, 32'h2, 32'h3, 8, 16'h0001, c));
`else
        c = 16'd2;
        go(0, 1, bub(c));
`endif
        go(1, 0, cap(32'h28, 32'h1, 32'h2, 32'h3, 8, 16'h0001, c));

        // producer of x9 sitting in MEM
        mem_reg_write_i = 1'b1; mem_rd_i = 5'd9; mem_result_i = 32'h99;
        drv(1, 32'h2C, 32'h5, 32'h6, 32'h0, 0, 9, 0, 0, 1, 16'h0000);
`ifdef ID_EX_FORWARDING_EN
        go(1, 0, cap(32'h2C, 32'h5, 32'h99, 32'h0, 0, 16'h0000, c));
        id_uses_rs2_i = 1'b0;
        go(1, 0, cap(32'h2C, 32'h5, 32'h99, 32'h0, 0, 16'h0000, c));
`else
        c = 16'd3;
        go(0, 1, bub(c));
        id_uses_rs2_i = 1'b0;
        go(1, 0, cap(32'h2C, 32'h5, 32'h6, 32'h0, 0, 16'h0000, c));
`endif
        mem_reg_write_i = 1'b0; mem_rd_i = '0; mem_result_i = '0;

        // downstream hold for three cycles around pc=0x100
        drv(1, 32'h100, 32'h1, 32'h2, 32'h3, 0, 0, 0, 0, 0, 16'h0008);
        go(1, 0, cap(32'h100, 32'h1, 32'h2, 32'h3, 0, 16'h0008, c));
        drv(1, 32'h104, 32'h4, 32'h5, 32'h6, 0, 0, 0, 0, 0, 16'h0010);
        ex_stall_i = 1'b1;
        for (int i = 0; i < 3; i++)
            go(0, 0, cap(32'h100, 32'h1, 32'h2, 32'h3, 0, 16'h0008, c));
        ex_stall_i = 1'b0;
        go(1, 0, cap(32'h104, 32'h4, 32'h5, 32'h6, 0, 16'h0010, c));

        // flush wins over a simultaneous stall
        flush_i = 1'b1; ex_stall_i = 1'b1;
        drv(1, 32'h108, 32'h7, 32'h8, 32'h9, 0, 0, 0, 0, 0, 16'h0001);
        go(0, -1, bub(c));
        flush_i = 1'b0; ex_stall_i = 1'b0;

        // flush wins over a load-use hazard and is not counted
        drv(1, 32'h200, 32'h1, 32'h1, 32'h1, 0, 0, 5, 0, 0, 16'h0003);
        go(1, 0, cap(32'h200, 32'h1, 32'h1, 32'h1, 5, 16'h0003, c));
        flush_i = 1'b1;
        drv(1, 32'h204, 32'h2, 32'h2, 32'h2, 5, 0, 6, 1, 0, 16'h0001);
        go(0, -1, bub(c));
        flush_i = 1'b0;

        // load into x0 never stalls its consumer
        drv(1, 32'h300, 32'h3, 32'h3, 32'h3, 0, 0, 0, 0, 0, 16'h0003);
        go(1, 0, cap(32'h300, 32'h3, 32'h3, 32'h3, 0, 16'h0003, c));
        drv(1, 32'h304, 32'h4, 32'h4, 32'h4, 0, 0, 0, 1, 1, 16'h0001);
        go(1, 0, cap(32'h304, 32'h4, 32'h4, 32'h4, 0, 16'h0001, c));

`ifdef ID_EX_FORWARDING_EN
        mem_reg_write_i = 1'b1; mem_rd_i = 5'd3; mem_result_i = 32'hAAAA;
        wb_reg_write_i = 1'b1; wb_rd_i = 5'd3; wb_result_i = 32'hBBBB;
        drv(1, 32'h308, 32'h1234, 32'h2, 32'h0, 3, 0, 0, 1, 0, 16'h0000);
        go(1, 0, cap(32'h308, 32'hAAAA, 32'h2, 32'h0, 0, 16'h0000, c));
        mem_rd_i = 5'd0;
        drv(1, 32'h30C, 32'h5678, 32'h2, 32'h0, 0, 0, 0, 1, 0, 16'h0000);
        go(1, 0, cap(32'h30C, 32'h5678, 32'h2, 32'h0, 0, 16'h0000, c));
        mem_reg_write_i = 1'b0;
        drv(1, 32'h310, 32'h1, 32'h2222, 32'h0, 0, 3, 0, 0, 1, 16'h0000);
        go(1, 0, cap(32'h310, 32'h1, 32'hBBBB, 32'h0, 0, 16'h0000, c));
        wb_reg_write_i = 1'b0; wb_rd_i = '0;
`endif

        // async reset between edges while stalled
        drv(1, 32'h400, 32'h40, 32'h41, 32'h42, 0, 0, 7, 0, 0, 16'h0001);
        go(1, 0, cap(32'h400, 32'h40, 32'h41, 32'h42, 7, 16'h0001, c));
        ex_stall_i = 1'b1;
        #2 rst_i = 1'b1;
        #1 chk_all_zero("async_rst");
        @(negedge clk);
        rst_i = 1'b0; ex_stall_i = 1'b0;
        c = 16'd0;
        drv(1, 32'h500, 32'h50, 32'h51, 32'h52, 0, 0, 0, 0, 0, 16'h0000);
        go(1, 0, cap(32'h500, 32'h50, 32'h51, 32'h52, 0, 16'h0000, c));

`ifndef ID_EX_FORWARDING_EN
        // a MEM producer held in place forces a bubble every cycle
        mem_reg_write_i = 1'b1; mem_rd_i = 5'd5;
        drv(1, 32'h600, 32'h0, 32'h0, 32'h0, 5, 0, 0, 1, 0, 16'h0001);
        for (int i = 1; i <= 65540; i++) begin
            if (i == 1 || i == 65534 || i == 65535 || i == 65540)
                go(0, 1, bub((i >= 65535) ? 16'hFFFF : 16'(i)));
            else
                @(negedge clk);
        end
        mem_reg_write_i = 1'b0;
`endif

        id_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("scoreboard_drain", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
